// File: rtl/text_console_if.sv
// Byte-stream input handshake plus single-byte screen RAM write bus.
// Combinational bundle only, so it adds no latency of its own.
// Backpressure: ch_ready_o gates the byte stream, and ack_i stalls the bus.
interface text_console_if;
    logic [7:0]  ch_i;
    logic        ch_valid_i;
    logic        ch_ready_o;
    logic [12:0] adr_o;
    logic [31:0] dat_o;
    logic [3:0]  sel_o;
    logic        we_o;
    logic        stb_o;
    logic        ack_i;

    // The console side: consumes bytes and masters the RAM bus.
    modport master (
        input  ch_i, ch_valid_i, ack_i,
        output ch_ready_o, adr_o, dat_o, sel_o, we_o, stb_o
    );

    // The environment side: byte source and video RAM slave.
    modport slave (
        output ch_i, ch_valid_i, ack_i,
        input  ch_ready_o, adr_o, dat_o, sel_o, we_o, stb_o
    );
endinterface

// File: rtl/text_console.sv
// Text console: turns a byte stream into cursor-tracked screen RAM writes.
// Latency: a printable byte is accepted at N, stb at N+1, ready again at N+2 with a zero-wait slave.
// Backpressure: ready is low outside IDLE; every bus write is held until ack_i.
module text_console #(
    parameter int          COLS  = 80,
    parameter int          ROWS  = 60,
    parameter logic [7:0]  BLANK = 8'h00
) (
    input  logic           clk_25mhz,
    input  logic           rst,
    text_console_if.master bus,
    output logic [6:0]     cur_col_o,
    output logic [5:0]     cur_row_o,
    output logic           busy_o
);
    typedef enum logic [1:0] {IDLE, PUT, CLR_LINE, CLR_SCREEN} state_t;

    localparam logic [6:0]  COL_LAST    = 7'(COLS - 1);
    localparam logic [5:0]  ROW_LAST    = 6'(ROWS - 1);
    localparam logic [12:0] LINE_LAST   = 13'(COLS - 1);
    localparam logic [12:0] SCREEN_LAST = 13'(ROWS * COLS - 1);

    state_t      state_q, state_d;
    logic [6:0]  col_q, col_d;
    logic [5:0]  row_q, row_d;
    logic [12:0] adr_q, adr_d;
    logic [7:0]  byte_q, byte_d;
    logic        bs_q, bs_d;      // current PUT is a backspace blank
    logic [12:0] cnt_q, cnt_d;    // cells already cleared in a clear run

    logic        stb;
    logic        ack;
    logic        accept;
    logic [5:0]  next_row;
    logic [12:0] cur_base;
    logic [12:0] next_base;

    // Bus request is simply "not idle" so an async reset drops it at once.
    assign stb      = (state_q != IDLE);
    assign ack      = stb && bus.ack_i;
    assign accept   = bus.ch_valid_i && (state_q == IDLE);
    assign next_row = (row_q == ROW_LAST) ? 6'd0 : row_q + 6'd1;
    assign cur_base  = 13'(row_q) * 13'(COLS);
    assign next_base = 13'(next_row) * 13'(COLS);

    assign bus.ch_ready_o = (state_q == IDLE);
    assign bus.stb_o      = stb;
    assign bus.we_o       = stb;
    assign bus.adr_o      = adr_q;
    assign bus.dat_o      = {24'h0, byte_q};
    assign bus.sel_o      = 4'b0001;
    assign cur_col_o      = col_q;
    assign cur_row_o      = row_q;
    assign busy_o         = stb;

    // Next-state and datapath decode: byte commands in IDLE, write sequencing elsewhere.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        adr_d   = adr_q;
        byte_d  = byte_q;
        bs_d    = bs_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    unique case (bus.ch_i)
                        8'h0D: col_d = 7'd0;
                        8'h0A: begin
                            row_d   = next_row;
                            adr_d   = next_base;
                            byte_d  = BLANK;
                            cnt_d   = 13'd0;
                            state_d = CLR_LINE;
                        end
                        8'h08: begin
                            if (col_q != 7'd0) begin
                                col_d   = col_q - 7'd1;
                                adr_d   = cur_base + 13'(col_q) - 13'd1;
                                byte_d  = BLANK;
                                bs_d    = 1'b1;
                                state_d = PUT;
                            end
                        end
                        8'h0C: begin
                            col_d   = 7'd0;
                            row_d   = 6'd0;
                            adr_d   = 13'd0;
                            byte_d  = BLANK;
                            cnt_d   = 13'd0;
                            state_d = CLR_SCREEN;
                        end
                        default: begin
                            adr_d   = cur_base + 13'(col_q);
                            byte_d  = bus.ch_i;
                            bs_d    = 1'b0;
                            state_d = PUT;
                        end
                    endcase
                end
            end
            PUT: begin
                if (ack) begin
                    if (bs_q) begin
                        state_d = IDLE;
                    end else if (col_q == COL_LAST) begin
                        // Wrapping onto a new line clears that line before more text lands.
                        col_d   = 7'd0;
                        row_d   = next_row;
                        adr_d   = next_base;
                        byte_d  = BLANK;
                        cnt_d   = 13'd0;
                        state_d = CLR_LINE;
                    end else begin
                        col_d   = col_q + 7'd1;
                        state_d = IDLE;
                    end
                end
            end
            CLR_LINE: begin
                if (ack) begin
                    if (cnt_q == LINE_LAST) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 13'd1;
                        adr_d = adr_q + 13'd1;
                    end
                end
            end
            CLR_SCREEN: begin
                if (ack) begin
                    if (cnt_q == SCREEN_LAST) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 13'd1;
                        adr_d = adr_q + 13'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any write in progress.
    always_ff @(posedge clk_25mhz or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            col_q   <= 7'd0;
            row_q   <= 6'd0;
            adr_q   <= 13'd0;
            byte_q  <= 8'h00;
            bs_q    <= 1'b0;
            cnt_q   <= 13'd0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            adr_q   <= adr_d;
            byte_q  <= byte_d;
            bs_q    <= bs_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_text_console.sv
// Directed bench for text_console: zero-wait slave, ack stalls and reset aborts.
module tb_text_console;
    logic       clk_25mhz = 1'b0;
    logic       rst = 1'b1;
    logic       ack_hold = 1'b0;
    logic [6:0] cur_col_o;
    logic [5:0] cur_row_o;
    logic       busy_o;

    int errors = 0;
    int checks = 0;

    logic [12:0] log_adr[$];
    logic [31:0] log_dat[$];

    text_console_if bus ();

    text_console dut (
        .clk_25mhz (clk_25mhz),
        .rst       (rst),
        .bus       (bus.master),
        .cur_col_o (cur_col_o),
        .cur_row_o (cur_row_o),
        .busy_o    (busy_o)
    );

    always #20 clk_25mhz = ~clk_25mhz;

    // Zero-wait slave unless the bench holds ack off.
    assign bus.ack_i = bus.stb_o && !ack_hold;

    // A transfer pending at the negedge completes at the following posedge.
    always @(negedge clk_25mhz) begin
        if (!rst && bus.stb_o && bus.ack_i) begin
            log_adr.push_back(bus.adr_o);
            log_dat.push_back(bus.dat_o);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        log_adr.delete();
        log_dat.delete();
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        @(negedge clk_25mhz);
        while (!bus.ch_ready_o && n < 10000) begin
            @(negedge clk_25mhz);
            n++;
        end
        if (n >= 10000) chk("send_timeout", 32'(n), 32'd0);
        bus.ch_i       = b;
        bus.ch_valid_i = 1'b1;
        @(posedge clk_25mhz);
        #1;
        bus.ch_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk_25mhz);
        while (!bus.ch_ready_o && n < 10000) begin
            @(negedge clk_25mhz);
            n++;
        end
        chk("idle_reached", 32'(bus.ch_ready_o), 32'd1);
    endtask

    // Compares the log against a run of ascending addresses with a constant byte.
    task automatic chk_run(input string tag, input int first, input int base, input int len,
                           input logic [7:0] b);
        int bad = 0;
        for (int i = 0; i < len; i++) begin
            if (first + i >= log_adr.size()) bad++;
            else if (log_adr[first + i] !== 13'(base + i) || log_dat[first + i] !== {24'h0, b}) bad++;
        end
        chk(tag, 32'(bad), 32'd0);
    endtask

    initial begin
        int cnt;
        bus.ch_i       = 8'h00;
        bus.ch_valid_i = 1'b0;

        // Reset state
        #5;
        chk("rst_stb", 32'(bus.stb_o), 32'd0);
        chk("rst_we", 32'(bus.we_o), 32'd0);
        chk("rst_adr", 32'(bus.adr_o), 32'd0);
        chk("rst_dat", bus.dat_o, 32'd0);
        chk("rst_ready", 32'(bus.ch_ready_o), 32'd1);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_col", 32'(cur_col_o), 32'd0);
        chk("rst_row", 32'(cur_row_o), 32'd0);
        @(negedge clk_25mhz);
        rst = 1'b0;

        // Single printable byte
        clear_log();
        send(8'h41);
        chk("a_stb", 32'(bus.stb_o), 32'd1);
        chk("a_we", 32'(bus.we_o), 32'd1);
        chk("a_adr", 32'(bus.adr_o), 32'd0);
        chk("a_dat", bus.dat_o, 32'h41);
        chk("a_sel", 32'(bus.sel_o), 32'b0001);
        chk("a_ready_low", 32'(bus.ch_ready_o), 32'd0);
        @(posedge clk_25mhz); #1;
        chk("a_ready_n2", 32'(bus.ch_ready_o), 32'd1);
        chk("a_stb_done", 32'(bus.stb_o), 32'd0);
        chk("a_col", 32'(cur_col_o), 32'd1);
        chk("a_row", 32'(cur_row_o), 32'd0);
        chk("a_nwrites", 32'(log_adr.size()), 32'd1);

        // Full line of 0x42 wraps and clears row 1
        send(8'h0D);
        chk("cr_col", 32'(cur_col_o), 32'd0);
        clear_log();
        for (int i = 0; i < 80; i++) send(8'h42);
        cnt = 0;
        @(negedge clk_25mhz);
        while (!bus.ch_ready_o && cnt < 1000) begin
            if (cnt == 5) chk("wrap_cursor_mid", {25'd0, cur_col_o}, 32'd0);
            cnt++;
            @(negedge clk_25mhz);
        end
        chk("wrap_ready_low", 32'(cnt), 32'd81);
        chk("wrap_nwrites", 32'(log_adr.size()), 32'd160);
        chk_run("wrap_text", 0, 0, 80, 8'h42);
        chk_run("wrap_clear", 80, 80, 80, 8'h00);
        chk("wrap_col", 32'(cur_col_o), 32'd0);
        chk("wrap_row", 32'(cur_row_o), 32'd1);

        // Move to row 59, col 10, then LF wraps to row 0
        for (int i = 0; i < 58; i++) send(8'h0A);
        for (int i = 0; i < 10; i++) send(8'h78);
        wait_idle();
        chk("pos_col", 32'(cur_col_o), 32'd10);
        chk("pos_row", 32'(cur_row_o), 32'd59);
        clear_log();
        send(8'h0A);
        chk("lf_mid_row", 32'(cur_row_o), 32'd0);
        chk("lf_mid_col", 32'(cur_col_o), 32'd10);
        wait_idle();
        chk("lf_nwrites", 32'(log_adr.size()), 32'd80);
        chk_run("lf_clear", 0, 0, 80, 8'h00);
        clear_log();
        send(8'h0D);
        chk("cr_ready", 32'(bus.ch_ready_o), 32'd1);
        repeat (3) @(negedge clk_25mhz);
        chk("cr_nwrites", 32'(log_adr.size()), 32'd0);
        chk("cr2_col", 32'(cur_col_o), 32'd0);
        chk("cr2_row", 32'(cur_row_o), 32'd0);

        // Backspace at col 0 and at (5,2)
        clear_log();
        send(8'h08);
        chk("bs0_stb", 32'(bus.stb_o), 32'd0);
        repeat (3) @(negedge clk_25mhz);
        chk("bs0_nwrites", 32'(log_adr.size()), 32'd0);
        chk("bs0_col", 32'(cur_col_o), 32'd0);
        chk("bs0_row", 32'(cur_row_o), 32'd0);
        send(8'h0A);
        send(8'h0A);
        for (int i = 0; i < 5; i++) send(8'h79);
        wait_idle();
        clear_log();
        send(8'h08);
        wait_idle();
        chk("bs_nwrites", 32'(log_adr.size()), 32'd1);
        chk_run("bs_write", 0, 164, 1, 8'h00);
        chk("bs_col", 32'(cur_col_o), 32'd4);
        chk("bs_row", 32'(cur_row_o), 32'd2);

        // Form feed clears the whole screen
        clear_log();
        send(8'h0C);
        chk("ff_col", 32'(cur_col_o), 32'd0);
        chk("ff_row", 32'(cur_row_o), 32'd0);
        cnt = 0;
        @(negedge clk_25mhz);
        while (busy_o && cnt < 6000) begin
            cnt++;
            @(negedge clk_25mhz);
        end
        chk("ff_busy_len", 32'(cnt), 32'd4800);
        chk("ff_busy_after", 32'(busy_o), 32'd0);
        chk("ff_nwrites", 32'(log_adr.size()), 32'd4800);
        chk_run("ff_clear", 0, 0, 4800, 8'h00);

        // Ack stall during a PUT
        clear_log();
        ack_hold = 1'b1;
        send(8'h5A);
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_25mhz);
            if (bus.stb_o !== 1'b1 || bus.adr_o !== 13'd0 || bus.dat_o !== 32'h5A) cnt++;
        end
        chk("stall_stable", 32'(cnt), 32'd0);
        @(posedge clk_25mhz); #1;
        ack_hold = 1'b0;
        wait_idle();
        chk("stall_nwrites", 32'(log_adr.size()), 32'd1);
        chk_run("stall_write", 0, 0, 1, 8'h5A);
        chk("stall_col", 32'(cur_col_o), 32'd1);

        // Reset in the middle of a screen clear
        send(8'h0C);
        cnt = 0;
        @(negedge clk_25mhz);
        while (bus.adr_o !== 13'd1000 && cnt < 2000) begin
            cnt++;
            @(negedge clk_25mhz);
        end
        chk("ff_reach_1000", 32'(bus.adr_o), 32'd1000);
        #1 rst = 1'b1;
        #1;
        chk("rr_stb", 32'(bus.stb_o), 32'd0);
        chk("rr_ready", 32'(bus.ch_ready_o), 32'd1);
        chk("rr_col", 32'(cur_col_o), 32'd0);
        chk("rr_row", 32'(cur_row_o), 32'd0);
        @(negedge clk_25mhz);
        rst = 1'b0;
        clear_log();
        repeat (20) @(negedge clk_25mhz);
        chk("rr_nwrites", 32'(log_adr.size()), 32'd0);
        chk("rr_busy", 32'(busy_o), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/text_console.md
Name: text_console

Overview:
- Upstream feeder for the 80x60 text-mode video block.
- Accepts a byte stream (CPU/UART terminal output) over a valid/ready handshake and tracks a cursor.
- Turns each byte into single-byte Wishbone-style writes into screen RAM: printable glyph, control codes, line clear and screen clear.
- The master port connects directly to the video slave port (adr/dat/sel/we/stb/ack).

Parameters:
- COLS, 80: characters per row.
- ROWS, 60: rows per screen.
- BLANK, 8'h00: byte written when clearing cells (blank glyph).

Ports:
- clk_25mhz  input  1  system/pixel clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- ch_i  input  8  character/control byte.
- ch_valid_i  input  1  ch_i valid.
- ch_ready_o  output  1  block can accept a byte this cycle.
- adr_o  output  13  screen RAM cell index (row*COLS+col).
- dat_o  output  32  write data, {24'h0, byte}.
- sel_o  output  4  byte select, constant 4'b0001.
- we_o  output  1  write enable, equals stb_o.
- stb_o  output  1  bus request.
- ack_i  input  1  slave acknowledge. A transfer completes on a cycle where stb_o && ack_i.
- cur_col_o  output  7  cursor column, 0..COLS-1.
- cur_row_o  output  6  cursor row, 0..ROWS-1.
- busy_o  output  1  high whenever state != IDLE.

Behaviour:
- Reset (asynchronous, immediate):
  - State = IDLE; stb_o = we_o = 0; adr_o = 0; dat_o = 0; cursor = (0,0); ch_ready_o = 1; busy_o = 0.
  - Screen contents are not cleared.
- States: IDLE, PUT, CLR_LINE, CLR_SCREEN.
- ch_ready_o = (state == IDLE). A byte is accepted on a cycle with ch_valid_i && ch_ready_o.
- Accepted byte decode (effective at the next edge):
  - 0x0D CR: col = 0. No bus write. Stays IDLE, so ready stays high.
  - 0x0A LF: row = row+1, wrapping ROWS-1 -> 0. col unchanged. Go to CLR_LINE for the new row.
  - 0x08 BS:
    - col > 0: col = col-1, then PUT of BLANK at the new position.
    - col == 0: no effect, no write.
  - 0x0C FF: cursor = (0,0); go to CLR_SCREEN.
  - Any other byte: PUT of the byte at the current cursor.
- PUT:
  - stb_o = 1 with adr_o = row*COLS+col and dat_o[7:0] = byte, all registered, asserted the cycle after acceptance.
  - adr_o/dat_o are held stable until ack_i.
  - On ack after a printable byte: col = col+1.
    - If col was COLS-1: col = 0, row = row+1 (wraps ROWS-1 -> 0), then go to CLR_LINE.
    - Otherwise go to IDLE.
  - On ack after BS: go to IDLE, cursor unchanged.
- CLR_LINE:
  - COLS writes of BLANK to addresses row*COLS+0 .. row*COLS+COLS-1, ascending.
  - The counter advances only on ack; stb_o stays high between writes.
  - IDLE after the last ack.
- CLR_SCREEN:
  - ROWS*COLS writes of BLANK, addresses 0 .. ROWS*COLS-1, ascending.
  - IDLE after the last ack.
- Address arithmetic:
  - row*COLS is computed in 13 bits; no overflow for the defaults (max 4799).
  - Wrap comparisons use COLS-1 and ROWS-1 exactly.
- Timing with a zero-wait slave (ack = stb):
  - Printable byte: accepted at cycle N, stb_o at N+1, IDLE/ready at N+2. One char per 2 cycles.
  - Line clear: ready low for COLS+1 cycles after acceptance.
- No scrolling. The cursor wraps to the top and the destination line is cleared first.
- Cursor outputs always show the committed position. During CLR_LINE they already show the new line, col 0 (LF keeps col).
- Reset asserted mid-PUT or mid-clear: stb_o drops in the same cycle. The partial clear is abandoned and no further writes occur.

Test Plan:
- After reset, send 'A' (0x41) with zero-wait ack -> one write: adr_o = 0, dat_o = 32'h41, sel_o = 4'b0001. Cursor (1,0). ch_ready_o high 2 cycles after acceptance.
- Send 80 bytes of 0x42 from (0,0) -> writes to adr 0..79. Then 80 BLANK writes to adr 80..159. Cursor (0,1). ready low for exactly 81 cycles after the 80th byte.
- Set the cursor to row 59, col 10 (CR/LF sequence); send LF -> 80 BLANK writes to adr 0..79; cursor (10,0). Send CR -> no bus activity, cursor (0,0).
- BS at col 0 -> no stb_o, cursor unchanged. BS at col 5, row 2 -> one BLANK write at adr 164; cursor (4,2).
- FF -> 4800 BLANK writes, adr 0..4799 in order; cursor (0,0); busy_o high throughout, low afterwards.
- Stall ack_i low for 3 cycles during a PUT -> stb_o, adr_o and dat_o stable across the stall; exactly one write counted. Assert rst during CLR_SCREEN at adr 1000 -> stb_o low in the same cycle, cursor (0,0), ready high, no further writes.
